// File: rtl/window_generator_pkg.sv
// Shared helpers for the sliding-window generator: constant clog2 used to
// size the column/row counters and the row-buffer pointers.
package window_generator_pkg;

  // Default geometry for the convolution front end.
  localparam int DEF_BIT_WIDTH   = 16;
  localparam int DEF_IMG_WIDTH   = 8;
  localparam int DEF_IMG_HEIGHT  = 8;
  localparam int DEF_KERNEL_SIZE = 3;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int value);
    int w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/window_generator_row_buffer.sv
// Fixed-length line delay: every enable pulse writes one pixel and presents
// the pixel written BUF_DEPTH enables earlier. Storage is a plain array with
// a registered read so it maps onto block RAM.
module window_generator_row_buffer
  import window_generator_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int BUF_DEPTH = DEF_IMG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] write_data,
  output logic [BIT_WIDTH-1:0] read_data
);

  localparam int PTR_W = cnt_width(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [BIT_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     ptr_next;
  logic [BIT_WIDTH-1:0] read_data_reg;

  // The slot after the write pointer holds the oldest pixel; it is also
  // where the next write goes, so one address serves both purposes.
  assign ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;

  // Line storage write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (enable) begin
      mem[wr_ptr_reg] <= write_data;
    end
  end

  // Pointer advance and registered read of the oldest pixel. Reading the
  // slot ahead of the write keeps the read/write addresses distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      read_data_reg <= '0;
    end else if (enable) begin
      wr_ptr_reg    <= ptr_next;
      read_data_reg <= mem[ptr_next];
    end
  end

  assign read_data = read_data_reg;

endmodule

// File: rtl/window_generator.sv
// Raster pixel stream -> KERNEL_SIZE x KERNEL_SIZE sliding windows (stride 1,
// no padding). K-1 chained line delays feed the upper window rows; the window
// register doubles as the single output stage toward the PE array.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        clear,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [BIT_WIDTH-1:0]                        in_data,
  output logic                                        win_valid,
  input  logic                                        win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*BIT_WIDTH-1:0] win_data,
  output logic                                        win_last
);

  localparam int K        = KERNEL_SIZE;
  localparam int WIN_TAPS = K * K;
  localparam int WIN_BITS = WIN_TAPS * BIT_WIDTH;
  localparam int COL_W    = cnt_width(IMG_WIDTH);
  localparam int ROW_W    = cnt_width(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

  logic                 accept;
  logic                 take;
  logic                 col_wrap;
  logic                 row_wrap;
  logic                 win_valid_next;
  logic                 win_last_next;
  logic [COL_W-1:0]     col_cnt_reg;
  logic [ROW_W-1:0]     row_cnt_reg;
  logic                 win_valid_reg;
  logic                 win_last_reg;
  logic [BIT_WIDTH-1:0] win_reg [K][K];
  logic [BIT_WIDTH-1:0] rb_rd   [K-1];
  logic [BIT_WIDTH-1:0] rb_wr   [K-1];
  logic [WIN_BITS-1:0]  win_flat;

  // The output stage can take a new window when it is empty or draining.
  assign in_ready = !win_valid_reg || win_ready;
  assign accept   = in_valid && in_ready;
  // A clear cycle discards the presented pixel and leaves storage alone.
  assign take     = accept && !clear;

  assign col_wrap = (col_cnt_reg == COL_LAST);
  assign row_wrap = (row_cnt_reg == ROW_LAST);

  // Window status for the pixel being accepted, from pre-increment counts;
  // the column test also hides windows straddling the previous row.
  assign win_valid_next = (row_cnt_reg >= ROW_FIRST) && (col_cnt_reg >= COL_FIRST);
  assign win_last_next  = row_wrap && col_wrap;

  // Line delay chain: rb 0 sees the raw stream, each later buffer sees the
  // output of the one before, so buffer i lags by i+1 rows.
  generate
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_rb
      logic [BIT_WIDTH-1:0] rd_data;

      if (gi == 0) begin : g_head
        assign rb_wr[gi] = in_data;
      end else begin : g_tail
        assign rb_wr[gi] = rb_rd[gi-1];
      end

      window_generator_row_buffer #(
        .BIT_WIDTH (BIT_WIDTH),
        .BUF_DEPTH (IMG_WIDTH)
      ) u_row_buffer (
        .clk        (clk),
        .rst        (~rst_n),
        .enable     (take),
        .write_data (rb_wr[gi]),
        .read_data  (rd_data)
      );

      assign rb_rd[gi] = rd_data;
    end
  endgenerate

  // Window register: shift every row left and load the new right column,
  // newest pixel at the bottom, oldest line-delay output at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (take) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
      end
      win_reg[K-1][K-1] <= in_data;
      for (int i = 0; i < K - 1; i++) begin
        win_reg[K-2-i][K-1] <= rb_rd[i];
      end
    end
  end

  // Raster position counters and output valid/last flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_reg   <= '0;
      row_cnt_reg   <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
    end else if (clear) begin
      col_cnt_reg   <= '0;
      row_cnt_reg   <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
    end else if (accept) begin
      col_cnt_reg   <= col_wrap ? '0 : col_cnt_reg + 1'b1;
      if (col_wrap) begin
        row_cnt_reg <= row_wrap ? '0 : row_cnt_reg + 1'b1;
      end
      win_valid_reg <= win_valid_next;
      win_last_reg  <= win_last_next;
    end else if (win_ready) begin
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
    end
  end

  // Flatten taps: (r,c) lands at [(r*K+c)*BIT_WIDTH +: BIT_WIDTH].
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_row
      for (genvar gj = 0; gj < K; gj++) begin : g_col
        assign win_flat[(gi*K+gj)*BIT_WIDTH +: BIT_WIDTH] = win_reg[gi][gj];
      end
    end
  endgenerate

  assign win_data  = win_flat;
  assign win_valid = win_valid_reg;
  assign win_last  = win_last_reg;

endmodule
